// File: rtl/scoreboard_pkg.sv
// Shared constants and helpers for the scoreboard display path.
package scoreboard_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Rotated priority search: first enabled channel strictly after ptr, cyclically.
module rr_next_sel
  import scoreboard_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic [SEL_W-1:0]  ptr,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [SEL_W-1:0]  next_idx,
  output logic              any_en,
  output logic              wrapped
);

  // Distance 1..NUM_CH going forward from 'from'; the channel itself is NUM_CH away.
  function automatic int fwd_dist(input int from, input int to);
    return ((to - from + NUM_CH - 1) % NUM_CH) + 1;
  endfunction

  int best_d;

  always_comb begin
    next_idx = ptr;
    best_d   = NUM_CH + 1;
    any_en   = |ch_en;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en[i] && (fwd_dist(int'(ptr), i) < best_d)) begin
        best_d   = fwd_dist(int'(ptr), i);
        next_idx = SEL_W'(i);
      end
    end
    wrapped = any_en && (next_idx <= ptr);
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N:1 channel mux with manual select or auto scan over enabled channels.
module chan_scan_mux
  import scoreboard_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = sel_width(NUM_CH),
  localparam int DW_W   = sel_width(DWELL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         man_sel,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     hold,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]        q,
  output logic [SEL_W-1:0]         q_sel,
  output logic                     q_valid,
  output logic                     wrap
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic [SEL_W-1:0]  next_idx;
  logic              any_en, wrapped;
  logic [DATA_W-1:0] cur_data, man_data;
  logic              cur_en, man_ok;

  rr_next_sel #(.NUM_CH(NUM_CH)) u_next (
    .ptr      (ptr_q),
    .ch_en    (ch_en),
    .next_idx (next_idx),
    .any_en   (any_en),
    .wrapped  (wrapped)
  );

  // Channel lookup by pointer and by manual select; out-of-range selects match nothing.
  always_comb begin
    cur_data = '0;
    cur_en   = 1'b0;
    man_data = '0;
    man_ok   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ptr_q == SEL_W'(i)) begin
        cur_data = data_in[i*DATA_W +: DATA_W];
        cur_en   = ch_en[i];
      end
      if (man_sel == SEL_W'(i)) begin
        man_data = data_in[i*DATA_W +: DATA_W];
        man_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    data_d  = cur_data;
    sel_d   = ptr_q;
    valid_d = cur_en;
    wrap_d  = 1'b0;
    if (mode == MODE_MANUAL) begin
      dwell_d = '0;
      sel_d   = man_sel;
      data_d  = man_ok ? man_data : '0;
      valid_d = man_ok;
      if (man_ok) ptr_d = man_sel;
    end else if (!any_en) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!cur_en || (!hold && (dwell_q == DW_W'(DWELL - 1)))) begin
      // A disabled current channel is skipped at once, even under hold.
      ptr_d   = next_idx;
      dwell_d = '0;
      wrap_d  = wrapped;
    end else if (!hold) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      dwell_q <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q       = data_q;
  assign q_sel   = sel_q;
  assign q_valid = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed-vector bench for chan_scan_mux: a 4-channel table plus a 3-channel sequence.
module tb_chan_scan_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel DUT
  logic        mode, hold;
  logic [1:0]  man_sel;
  logic [3:0]  ch_en;
  logic [15:0] data_in;
  logic [3:0]  q;
  logic [1:0]  q_sel;
  logic        q_valid, wrap;

  // 3-channel DUT (non-power-of-2)
  logic        mode3, hold3;
  logic [1:0]  man_sel3;
  logic [2:0]  ch_en3;
  logic [11:0] data3;
  logic [3:0]  q3;
  logic [1:0]  q_sel3;
  logic        q_valid3, wrap3;

  chan_scan_mux #(.NUM_CH(4), .DATA_W(4), .DWELL(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .man_sel(man_sel), .ch_en(ch_en),
    .hold(hold), .data_in(data_in), .q(q), .q_sel(q_sel), .q_valid(q_valid),
    .wrap(wrap)
  );

  chan_scan_mux #(.NUM_CH(3), .DATA_W(4), .DWELL(4)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .man_sel(man_sel3), .ch_en(ch_en3),
    .hold(hold3), .data_in(data3), .q(q3), .q_sel(q_sel3), .q_valid(q_valid3),
    .wrap(wrap3)
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  en;
    logic        hold;
    logic [15:0] data;
    logic [3:0]  eq;
    logic [1:0]  esel;
    logic        ev;
    logic        ew;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                              input logic [3:0] e, input logic h, input logic [15:0] d,
                              input logic [3:0] eq, input logic [1:0] es,
                              input logic ev, input logic ew);
    vec_t v;
    v.rst = r; v.mode = m; v.sel = s; v.en = e; v.hold = h; v.data = d;
    v.eq = eq; v.esel = es; v.ev = ev; v.ew = ew;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic step3(input int idx, input logic [3:0] eq, input logic [1:0] es,
                       input logic ev, input logic ew);
    @(posedge clk); #1;
    cmp("q3",       idx, 32'(q3),       32'(eq));
    cmp("q_sel3",   idx, 32'(q_sel3),   32'(es));
    cmp("q_valid3", idx, 32'(q_valid3), 32'(ev));
    cmp("wrap3",    idx, 32'(wrap3),    32'(ew));
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; hold = 1'b0; man_sel = 2'd0; ch_en = 4'h0; data_in = 16'h0;
    mode3 = 1'b0; hold3 = 1'b0; man_sel3 = 2'd0; ch_en3 = 3'b000; data3 = 12'hCBA;

    // reset, manual select, reset again
    tv.push_back(mk(1, 0, 2'd0, 4'h0, 0, 16'h0000, 4'h0, 2'd0, 0, 0));
    tv.push_back(mk(0, 0, 2'd2, 4'h0, 0, 16'h0700, 4'h7, 2'd2, 1, 0));
    tv.push_back(mk(1, 0, 2'd2, 4'h0, 0, 16'h0700, 4'h0, 2'd0, 0, 0));
    // full-mask scan, four cycles per channel, wrap on the 3->0 advance
    for (int k = 1; k <= 17; k++)
      tv.push_back(mk(0, 1, 2'd0, 4'hF, 0, 16'h4321, 4'(((k - 1) / 4) % 4 + 1),
                      2'(((k - 1) / 4) % 4), 1, (k == 16)));
    // mask 1010: ch0 skipped at once, then 1 <-> 3
    tv.push_back(mk(0, 1, 2'd0, 4'hA, 0, 16'h4321, 4'h1, 2'd0, 0, 0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(0, 1, 2'd0, 4'hA, 0, 16'h4321, 4'h2, 2'd1, 1, 0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(0, 1, 2'd0, 4'hA, 0, 16'h4321, 4'h4, 2'd3, 1, (k == 3)));
    tv.push_back(mk(0, 1, 2'd0, 4'hA, 0, 16'h4321, 4'h2, 2'd1, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'hA, 0, 16'h4321, 4'h2, 2'd1, 1, 0));
    // ch1 disabled mid-dwell: move to ch2 next edge, dwell restarts
    tv.push_back(mk(0, 1, 2'd0, 4'hD, 0, 16'h4321, 4'h2, 2'd1, 0, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'hD, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'hD, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    // hold for 10 cycles while ch2 data changes
    for (int h = 0; h < 10; h++)
      tv.push_back(mk(0, 1, 2'd0, 4'hD, 1, {4'h4, 4'(h + 5), 4'h2, 4'h1},
                      4'(h + 5), 2'd2, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'hD, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'hD, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'hD, 0, 16'h4321, 4'h4, 2'd3, 1, 0));
    // empty mask freezes, then a single channel is picked up
    tv.push_back(mk(0, 1, 2'd0, 4'h0, 0, 16'h4321, 4'h0, 2'd3, 0, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'h0, 0, 16'h4321, 4'h0, 2'd3, 0, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'h4, 0, 16'h4321, 4'h4, 2'd3, 0, 1));
    tv.push_back(mk(0, 1, 2'd0, 4'h4, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'h4, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'h4, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    tv.push_back(mk(0, 1, 2'd0, 4'h4, 0, 16'h4321, 4'h3, 2'd2, 1, 1));
    tv.push_back(mk(0, 1, 2'd0, 4'h4, 0, 16'h4321, 4'h3, 2'd2, 1, 0));
    // back to manual, then reset while in auto
    tv.push_back(mk(0, 0, 2'd1, 4'h4, 0, 16'h4321, 4'h2, 2'd1, 1, 0));
    tv.push_back(mk(0, 0, 2'd3, 4'h4, 0, 16'h4321, 4'h4, 2'd3, 1, 0));
    tv.push_back(mk(0, 1, 2'd3, 4'hF, 0, 16'h4321, 4'h4, 2'd3, 1, 0));
    tv.push_back(mk(1, 1, 2'd3, 4'hF, 0, 16'h4321, 4'h0, 2'd0, 0, 0));

    @(negedge clk);
    foreach (tv[i]) begin
      rst = tv[i].rst; mode = tv[i].mode; man_sel = tv[i].sel; ch_en = tv[i].en;
      hold = tv[i].hold; data_in = tv[i].data;
      @(posedge clk); #1;
      cmp("q",       i, 32'(q),       32'(tv[i].eq));
      cmp("q_sel",   i, 32'(q_sel),   32'(tv[i].esel));
      cmp("q_valid", i, 32'(q_valid), 32'(tv[i].ev));
      cmp("wrap",    i, 32'(wrap),    32'(tv[i].ew));
    end

    // 3-channel build: out-of-range manual select, then auto from last legal select
    rst = 1'b1; mode = 1'b0;
    step3(100, 4'h0, 2'd0, 0, 0);
    rst = 1'b0; man_sel3 = 2'd1;
    step3(101, 4'hB, 2'd1, 1, 0);
    man_sel3 = 2'd3;
    step3(102, 4'h0, 2'd3, 0, 0);
    step3(103, 4'h0, 2'd3, 0, 0);
    mode3 = 1'b1; ch_en3 = 3'b111;
    for (int k = 0; k < 4; k++) step3(104 + k, 4'hB, 2'd1, 1, 0);
    for (int k = 0; k < 4; k++) step3(108 + k, 4'hC, 2'd2, 1, (k == 3));
    step3(112, 4'hA, 2'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
- Parametrised, registered N-to-1 channel multiplexer with a built-in auto-scan sequencer.
- It replaces fixed 4:1 combinational selection on the scoreboard display path.
- It rotates through enabled channels (runs, wickets, overs, target digits) with a programmable dwell time, or passes a manually selected channel.
- Output is registered and flagged valid. It feeds the 7-segment decode/drive stage.

Parameters:
- NUM_CH, 4, number of input channels (>=2)
- DATA_W, 4, bits per channel
- DWELL, 4, clock cycles each channel is presented in auto mode (>=1)
- SEL_W, $clog2(NUM_CH), select/pointer width (derived, not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- mode  input  1  0 = manual select, 1 = auto scan
- man_sel  input  SEL_W  channel index used in manual mode
- ch_en  input  NUM_CH  per-channel enable mask; bit i enables channel i in auto scan
- hold  input  1  auto mode only: freeze pointer and dwell counter
- data_in  input  NUM_CH*DATA_W  flattened channels; channel i = data_in[i*DATA_W +: DATA_W]
- q  output  DATA_W  registered selected data
- q_sel  output  SEL_W  index of channel currently on q
- q_valid  output  1  q holds a legal, enabled (auto) or in-range (manual) channel
- wrap  output  1  one-cycle pulse when the auto pointer wraps to a lower or equal index

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high.
- Reset values: ptr=0, dwell_cnt=0, q=0, q_sel=0, q_valid=0, wrap=0.
- Latency: 1 cycle. q/q_sel/q_valid reflect the pointer/man_sel and data_in sampled on the previous edge. data_in changes propagate even while the pointer is static.
- Manual mode (mode=0):
  - q <= channel[man_sel]; q_sel <= man_sel; q_valid <= 1.
  - ch_en is ignored in manual mode.
  - If man_sel >= NUM_CH: q <= 0, q_valid <= 0, q_sel <= man_sel.
  - ptr tracks man_sel when in range; dwell_cnt held at 0; wrap=0.
- Auto mode (mode=1) state: ptr, dwell_cnt in 0..DWELL-1.
  - Each cycle with hold=0: if dwell_cnt==DWELL-1, ptr <= next enabled index after ptr (cyclic search ptr+1 .. ptr+NUM_CH, modulo NUM_CH) and dwell_cnt <= 0. Otherwise dwell_cnt++.
  - wrap=1 on the cycle the advance is registered if new ptr <= old ptr. This includes a single enabled channel re-selecting itself.
  - q <= channel[ptr], q_sel <= ptr, q_valid <= ch_en[ptr].
- Current channel disabled (ch_en[ptr]==0, mask non-zero): advance immediately on the next edge regardless of dwell_cnt or hold. dwell_cnt <= 0. wrap rule applies.
- All-zero mask in auto mode: ptr and dwell_cnt frozen; q <= 0, q_valid <= 0, wrap=0. Scanning resumes from the next enabled index after ptr once any bit is set.
- hold=1 (auto, current channel enabled): ptr and dwell_cnt frozen; q continues to sample channel[ptr]; wrap=0.
- Mode 0->1 transition: ptr starts at the last in-range man_sel; dwell_cnt=0.
- Mode 1->0 transition: takes effect on the next edge, with no residual wrap.
- rst asserted mid-dwell or mid-advance: overrides all other inputs that cycle.
- Counters and pointer are unsigned.
- Index arithmetic wraps modulo NUM_CH. For non-power-of-2 NUM_CH, indices >= NUM_CH are never reached in auto mode.

Decomposition:
- Shared package scoreboard_pkg:
  - MODE_MANUAL=1'b0, MODE_AUTO=1'b1
  - function clog2-based SEL_W helper
  - default DATA_W/NUM_CH constants
- One combinational sub-module, rr_next_sel:
  - inputs: ptr, ch_en
  - outputs: next_idx, any_en, wrapped
  - implements the rotated priority search, so the sequencer stays purely register logic.

Test Plan:
- Reset, then mode=0, man_sel=2, channel2=4'h7 -> after 1 edge q=7, q_sel=2, q_valid=1. Assert rst for 1 cycle -> q=0, q_valid=0 next edge.
- Auto: DWELL=4, ch_en=4'b1111, channel i = i+1 -> q_sel sequence 0,0,0,0,1,1,1,1,2..3, then 0 with wrap=1 exactly on the 3->0 advance.
- ch_en=4'b1010 in auto -> q_sel visits only 1 and 3, alternating every 4 cycles. wrap pulses on each 3->1 advance.
- Auto at q_sel=1 with dwell_cnt=2, clear ch_en[1] -> next edge ptr=2, dwell restarts. hold=1 for 10 cycles -> q_sel constant, q follows changes on channel data.
- ch_en=0 in auto -> q_valid=0, q=0, ptr frozen. Set ch_en=4'b0100 -> q_sel=2, q_valid=1 within 2 edges.
- Manual man_sel=3 with NUM_CH=3 build -> q_valid=0, q=0. Switch to auto -> scanning starts at the last in-range man_sel with dwell_cnt=0.
